// File: rtl/ppm_freq_recovery_avg.sv
// rtl/ppm_freq_recovery_avg.sv - PPM pulse interval, symbol window and averaged frequency lock tracker
module ppm_freq_recovery_avg #(
  parameter int CHIP_BITS    = 1,
  parameter int SYMBOL_CHIPS = 16,
  parameter int CNT_WIDTH    = 8,
  parameter int AVG_LOG2     = 2,
  parameter int LOCK_TOL     = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 en,
  input  logic                 clear,
  input  logic [CHIP_BITS-1:0] din,
  input  logic [CHIP_BITS-1:0] pulse_threshold,
  output logic [CNT_WIDTH-1:0] interpulse_cycles,
  output logic                 interpulse_valid,
  output logic [1:0]           intrasymbol_pulses,
  output logic                 multi_pulse_err,
  output logic [CNT_WIDTH-1:0] avg_period,
  output logic                 avg_valid,
  output logic                 freq_ok
);
  localparam int ACC_W = CNT_WIDTH + AVG_LOG2;
  localparam int IDX_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0] WIN_LAST = CNT_WIDTH'(SYMBOL_CHIPS - 1);
  localparam logic [CNT_WIDTH-1:0] SYM      = CNT_WIDTH'(SYMBOL_CHIPS);
  localparam logic [CNT_WIDTH:0]   TOL      = (CNT_WIDTH + 1)'(LOCK_TOL);
  localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'((1 << AVG_LOG2) - 1);

  typedef enum logic {IDLE, COUNT} state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CNT_WIDTH-1:0] win_cnt_q, win_cnt_d;
  logic [1:0]           win_pulses_q, win_pulses_d;
  logic [CNT_WIDTH-1:0] ip_cycles_d, avg_d;
  logic [1:0]           isp_d;
  logic                 ip_valid_d, mpe_d, av_d, fok_d;

  logic                 pulse;
  logic [ACC_W-1:0]     sum;
  logic [CNT_WIDTH-1:0] sum_avg, diff;
  logic [1:0]           win_close;

  function automatic logic [1:0] sat_add(input logic [1:0] v, input logic p);
    return (p && v != 2'd3) ? v + 2'd1 : v;
  endfunction

  assign pulse     = en && (din >= pulse_threshold);
  assign sum       = acc_q + ACC_W'(cnt_q);
  assign sum_avg   = sum[ACC_W-1:AVG_LOG2];
  assign diff      = (sum_avg >= SYM) ? sum_avg - SYM : SYM - sum_avg;
  assign win_close = sat_add(win_pulses_q, pulse);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    idx_d        = idx_q;
    win_cnt_d    = win_cnt_q;
    win_pulses_d = win_pulses_q;
    ip_cycles_d  = interpulse_cycles;
    ip_valid_d   = 1'b0;
    isp_d        = intrasymbol_pulses;
    mpe_d        = 1'b0;
    avg_d        = avg_period;
    av_d         = 1'b0;
    fok_d        = freq_ok;
    if (en) begin
      case (state_q)
        IDLE: begin
          if (pulse) begin
            state_d      = COUNT;
            cnt_d        = CNT_WIDTH'(1);
            win_cnt_d    = CNT_WIDTH'(1);
            win_pulses_d = 2'd1;
          end
        end
        COUNT: begin
          if (pulse) begin
            ip_cycles_d = cnt_q;
            ip_valid_d  = 1'b1;
            cnt_d       = CNT_WIDTH'(1);
            if (idx_q == IDX_LAST) begin
              avg_d = sum_avg;
              av_d  = 1'b1;
              fok_d = ({1'b0, diff} <= TOL);
              acc_d = '0;
              idx_d = '0;
            end else begin
              acc_d = sum;
              idx_d = idx_q + IDX_W'(1);
            end
          end else if (cnt_q == CNT_MAX) begin
            state_d = IDLE;
            cnt_d   = '0;
            acc_d   = '0;
            idx_d   = '0;
            fok_d   = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
          // The timeout edge leaves the window result untouched.
          if (pulse || cnt_q != CNT_MAX) begin
            if (win_cnt_q == WIN_LAST) begin
              isp_d        = win_close;
              mpe_d        = (win_close >= 2'd2);
              win_cnt_d    = '0;
              win_pulses_d = 2'd0;
            end else begin
              win_cnt_d    = win_cnt_q + CNT_WIDTH'(1);
              win_pulses_d = win_close;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q            <= IDLE;
      cnt_q              <= '0;
      acc_q              <= '0;
      idx_q              <= '0;
      win_cnt_q          <= '0;
      win_pulses_q       <= 2'd0;
      interpulse_cycles  <= '0;
      interpulse_valid   <= 1'b0;
      intrasymbol_pulses <= 2'd0;
      multi_pulse_err    <= 1'b0;
      avg_period         <= '0;
      avg_valid          <= 1'b0;
      freq_ok            <= 1'b0;
    end else if (clear) begin
      state_q            <= IDLE;
      cnt_q              <= '0;
      acc_q              <= '0;
      idx_q              <= '0;
      win_cnt_q          <= '0;
      win_pulses_q       <= 2'd0;
      interpulse_cycles  <= '0;
      interpulse_valid   <= 1'b0;
      intrasymbol_pulses <= 2'd0;
      multi_pulse_err    <= 1'b0;
      avg_period         <= '0;
      avg_valid          <= 1'b0;
      freq_ok            <= 1'b0;
    end else begin
      state_q            <= state_d;
      cnt_q              <= cnt_d;
      acc_q              <= acc_d;
      idx_q              <= idx_d;
      win_cnt_q          <= win_cnt_d;
      win_pulses_q       <= win_pulses_d;
      interpulse_cycles  <= ip_cycles_d;
      interpulse_valid   <= ip_valid_d;
      intrasymbol_pulses <= isp_d;
      multi_pulse_err    <= mpe_d;
      avg_period         <= avg_d;
      avg_valid          <= av_d;
      freq_ok            <= fok_d;
    end
  end
endmodule

// File: tb/tb_ppm_freq_recovery_avg.sv
// tb/tb_ppm_freq_recovery_avg.sv - scoreboard bench for ppm_freq_recovery_avg
module tb_ppm_freq_recovery_avg;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn, en, clear;
  logic [0:0] din, thr;
  logic [7:0] ip, avg;
  logic       ipv, mpe, av, fok;
  logic [1:0] isp;

  logic       en3, clear3;
  logic [2:0] din3, thr3;
  logic [7:0] ip3, avg3;
  logic       ipv3, mpe3, av3, fok3;
  logic [1:0] isp3;

  ppm_freq_recovery_avg dut (
    .clk(clk), .resetn(resetn), .en(en), .clear(clear), .din(din), .pulse_threshold(thr),
    .interpulse_cycles(ip), .interpulse_valid(ipv), .intrasymbol_pulses(isp),
    .multi_pulse_err(mpe), .avg_period(avg), .avg_valid(av), .freq_ok(fok)
  );

  ppm_freq_recovery_avg #(.CHIP_BITS(3)) dut3 (
    .clk(clk), .resetn(resetn), .en(en3), .clear(clear3), .din(din3), .pulse_threshold(thr3),
    .interpulse_cycles(ip3), .interpulse_valid(ipv3), .intrasymbol_pulses(isp3),
    .multi_pulse_err(mpe3), .avg_period(avg3), .avg_valid(av3), .freq_ok(fok3)
  );

  typedef struct {
    int ip;
    bit av;
    int avg;
    bit fok;
  } exp_t;

  exp_t ip_q[$];
  int   n_assert = 0;
  int   n_fail = 0;
  int   m_acc, m_idx;
  bit   m_fok, m_started;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_acc = 0;
    m_idx = 0;
    m_fok = 1'b0;
    m_started = 1'b0;
    ip_q.delete();
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (ipv) begin
      if (ip_q.size() == 0) chk("unexpected_interval_strobe", 32'(ipv), 32'd0);
      else begin
        e = ip_q.pop_front();
        chk("interpulse_cycles", 32'(ip), 32'(e.ip));
        chk("avg_valid", 32'(av), 32'(e.av));
        if (e.av) chk("avg_period", 32'(avg), 32'(e.avg));
        chk("freq_ok", 32'(fok), 32'(e.fok));
      end
    end else begin
      chk("stray_avg_valid", 32'(av), 32'd0);
    end
  endtask

  task automatic idle(input int n);
    din = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Pulse after 'idles' quiet edges; exp_ip is the interval the bench expects reported.
  task automatic pulse_n(input int idles, input int exp_ip);
    exp_t e;
    bit   was_started;
    idle(idles);
    was_started = m_started;
    if (was_started) begin
      e.ip = exp_ip;
      e.av = (m_idx == 3);
      if (e.av) begin
        e.avg = (m_acc + exp_ip) / 4;
        m_fok = (((e.avg >= 16) ? e.avg - 16 : 16 - e.avg) <= 2);
        m_acc = 0;
        m_idx = 0;
      end else begin
        e.avg = 0;
        m_acc += exp_ip;
        m_idx++;
      end
      e.fok = m_fok;
      ip_q.push_back(e);
    end
    din = 1'b1;
    tick();
    din = 1'b0;
    if (was_started) chk("interval_strobe_seen", ip_q.size(), 32'd0);
    m_started = 1'b1;
  endtask

  task automatic pulse_gap(input int g);
    pulse_n(g - 1, g);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ip"}, 32'(ip), 32'd0);
    chk({tag, "_ipv"}, 32'(ipv), 32'd0);
    chk({tag, "_isp"}, 32'(isp), 32'd0);
    chk({tag, "_mpe"}, 32'(mpe), 32'd0);
    chk({tag, "_avg"}, 32'(avg), 32'd0);
    chk({tag, "_av"}, 32'(av), 32'd0);
    chk({tag, "_fok"}, 32'(fok), 32'd0);
  endtask

  initial begin
    resetn = 1'b0; en = 1'b1; clear = 1'b0; din = 1'b0; thr = 1'b1;
    en3 = 1'b1; clear3 = 1'b0; din3 = 3'd0; thr3 = 3'd4;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk) resetn = 1'b1;

    // Five pulses 16 apart lock on the fourth interval.
    pulse_gap(1);
    repeat (4) pulse_gap(16);
    chk("lock_interval", 32'(ip), 32'd16);
    chk("lock_avg", 32'(avg), 32'd16);
    chk("lock_avg_valid", 32'(av), 32'd1);
    chk("lock_freq_ok", 32'(fok), 32'd1);

    // Asynchronous reset in the middle of a count.
    idle(6);
    #3 resetn = 1'b0;
    #1 chk_all_zero("async_reset");
    @(negedge clk) resetn = 1'b1;
    model_reset();
    pulse_gap(1);
    chk("first_pulse_no_strobe", 32'(ipv), 32'd0);

    pulse_gap(10); pulse_gap(20); pulse_gap(14); pulse_gap(22);
    chk("set1_avg", 32'(avg), 32'd16);
    chk("set1_fok", 32'(fok), 32'd1);
    repeat (4) pulse_gap(20);
    chk("set2_avg", 32'(avg), 32'd20);
    chk("set2_fok", 32'(fok), 32'd0);
    pulse_gap(18); pulse_gap(18); pulse_gap(17); pulse_gap(18);
    chk("set3_avg", 32'(avg), 32'd17);
    chk("set3_fok", 32'(fok), 32'd1);
    repeat (4) pulse_gap(19);
    chk("set4_avg", 32'(avg), 32'd19);
    chk("set4_fok", 32'(fok), 32'd0);
    repeat (4) pulse_gap(18);
    chk("set5_avg", 32'(avg), 32'd18);
    chk("set5_fok", 32'(fok), 32'd1);

    // Partial accumulation, then timeout must discard it.
    pulse_gap(30); pulse_gap(30);
    idle(254);
    chk("pre_timeout_fok", 32'(fok), 32'd1);
    idle(1);
    chk("timeout_fok", 32'(fok), 32'd0);
    chk("timeout_ip_hold", 32'(ip), 32'd30);
    chk("timeout_avg_hold", 32'(avg), 32'd18);
    model_reset();
    pulse_gap(1);
    chk("post_timeout_first_no_strobe", 32'(ipv), 32'd0);
    repeat (4) pulse_gap(16);
    chk("relock_avg", 32'(avg), 32'd16);
    chk("relock_fok", 32'(fok), 32'd1);
    pulse_n(254, 255);
    chk("sat_interval", 32'(ip), 32'd255);
    pulse_gap(16);

    // Symbol window accounting from a cleared start.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk_all_zero("clear");
    model_reset();
    pulse_gap(1);
    pulse_gap(3);
    idle(11);
    chk("win1_pre_wrap_isp", 32'(isp), 32'd0);
    idle(1);
    chk("win1_isp", 32'(isp), 32'd2);
    chk("win1_mpe", 32'(mpe), 32'd1);
    idle(1);
    chk("win1_mpe_one_cycle", 32'(mpe), 32'd0);
    pulse_n(3, 17);
    idle(11);
    chk("win2_isp", 32'(isp), 32'd1);
    chk("win2_mpe", 32'(mpe), 32'd0);
    pulse_n(8, 20);
    pulse_n(6, 7);
    chk("win3_wrap_pulse_isp", 32'(isp), 32'd2);
    chk("win3_wrap_pulse_mpe", 32'(mpe), 32'd1);
    idle(16);
    chk("win4_isp", 32'(isp), 32'd0);
    chk("win4_mpe", 32'(mpe), 32'd0);

    // Enable gating freezes the counter and ignores pulses.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_reset();
    pulse_gap(1);
    idle(3);
    en = 1'b0;
    din = 1'b1;
    repeat (5) tick();
    en = 1'b1;
    din = 1'b0;
    pulse_n(2, 6);
    chk("en_frozen_cnt", 32'(ip), 32'd6);
    en = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    en = 1'b1;
    chk("clear_while_disabled_ip", 32'(ip), 32'd0);
    model_reset();
    pulse_gap(1);
    pulse_gap(5);

    // Multi-bit chip counts against a threshold of 4.
    din3 = 3'd4;
    tick();
    chk("w3_first_no_strobe", 32'(ipv3), 32'd0);
    din3 = 3'd3;
    repeat (5) tick();
    chk("w3_below_threshold", 32'(ipv3), 32'd0);
    din3 = 3'd5;
    tick();
    chk("w3_valid_a", 32'(ipv3), 32'd1);
    chk("w3_interval_a", 32'(ip3), 32'd6);
    din3 = 3'd3;
    repeat (2) tick();
    din3 = 3'd4;
    tick();
    chk("w3_valid_b", 32'(ipv3), 32'd1);
    chk("w3_interval_b", 32'(ip3), 32'd3);
    din3 = 3'd0;

    chk("scoreboard_drained", ip_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
